// File: rtl/sequence_detector.sv
// sequence_detector
//
// Watches a serial bit stream and flags every occurrence of the pattern
// 1-0-1-1-0-1 (oldest bit first). Occurrences may overlap: the trailing
// "101" of one match counts toward the next one. This is a Moore machine,
// so the flag is decoded from the state register alone.
//
// Ports:
//   clk       system clock; all state updates occur on the rising edge
//   reset     asynchronous, active-low reset (0 forces the idle state)
//   in        serial data bit, sampled on each rising edge of clk
//   detected  high for the one cycle after the edge that sampled the
//             sixth pattern bit
module sequence_detector (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic detected
);

  // Each state is named by the length of the pattern prefix matched so far.
  // The 3'b111 encoding is never entered, but it is listed so that the
  // recovery path back to idle is explicit.
  typedef enum logic [2:0] {
    S0     = 3'd0,  // nothing matched
    S1     = 3'd1,  // "1"
    S2     = 3'd2,  // "10"
    S3     = 3'd3,  // "101"
    S4     = 3'd4,  // "1011"
    S5     = 3'd5,  // "10110"
    S6     = 3'd6,  // "101101", full match
    SUNUSE = 3'd7
  } state_t;

  state_t state;
  state_t next;

  // State register. Reset is asynchronous and active-low, so any partial
  // match is discarded as soon as reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S0;
    end else begin
      state <= next;
    end
  end

  // Next-state logic. On a mismatch, the machine falls back to the longest
  // suffix of the bits seen so far that is still a pattern prefix. S6 ends
  // in "101", so it continues exactly as S3 does; this gives overlapping
  // detection.
  always_comb begin
    next = S0;
    unique case (state)
      S0:      next = in ? S1 : S0;
      S1:      next = in ? S1 : S2;
      S2:      next = in ? S3 : S0;
      S3:      next = in ? S4 : S2;
      S4:      next = in ? S1 : S5;
      S5:      next = in ? S6 : S0;
      S6:      next = in ? S4 : S2;
      default: next = S0;
    endcase
  end

  // The output depends only on the registered state. There is no path from
  // in to detected.
  assign detected = (state == S6);

endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector
//
// Scoreboard bench for sequence_detector. For every bit it drives, the
// driver pushes the expected detected value into a queue. The monitor pops
// one entry after each rising edge and compares it with the DUT output. It
// also flags any two consecutive cycles in which detected is high.
module tb_sequence_detector;

  logic clk;
  logic reset;
  logic in;
  logic detected;

  int checks;
  int errors;
  logic expQ[$];

  sequence_detector dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .detected (detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: checks the output a short time after each rising edge, once
  // for every bit the driver has issued.
  always @(posedge clk) begin : monitor
    logic expBit;
    logic prevDet;
    #1;
    if (!reset) begin
      prevDet = 1'b0;
    end else if (expQ.size() > 0) begin
      expBit = expQ.pop_front();
      checks++;
      if (detected !== expBit) begin
        errors++;
        $display("[TB] FAIL detect: got %b expected %b at %0t", detected, expBit, $time);
      end
      checks++;
      if (prevDet === 1'b1 && detected === 1'b1) begin
        errors++;
        $display("[TB] FAIL backToBack: got %b after %b expected 0 at %0t", detected, prevDet, $time);
      end
      prevDet = detected;
    end
  end

  // Direct check of the output at the current time.
  task automatic checkOutput(input string name, input logic expBit);
    checks++;
    if (detected !== expBit) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, detected, expBit, $time);
    end
  endtask

  // Drive one bit at the falling edge and queue its expected response.
  task automatic sendBit(input logic b, input logic expBit);
    @(negedge clk);
    in = b;
    expQ.push_back(expBit);
  endtask

  // Send n bits, oldest first. bits[n-1] is the first bit sent, and
  // exps[k] is the expected flag after bits[k].
  task automatic applyStimulus(input logic [15:0] bits, input logic [15:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sendBit(bits[i], exps[i]);
    end
  endtask

  // Hold reset low for two cycles while toggling in. The output must stay
  // low throughout.
  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("resetImmediate", 1'b0);
    for (int i = 0; i < 2; i++) begin
      in = ~in;
      @(posedge clk);
      #1 checkOutput("resetHold", 1'b0);
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  initial begin : driver
    logic [5:0] hist;
    logic b;
    checks = 0;
    errors = 0;
    in = 1'b0;
    reset = 1'b0;
    #2 checkOutput("resetStart", 1'b0);
    resetDut();

    // Basic match, then 0101 continuing from S6 (S2, S3, S2, S3).
    applyStimulus(16'b101101, 16'b000001, 6);
    applyStimulus(16'b0101, 16'b0000, 4);

    // Overlap: pulses after bit 6 and bit 9.
    resetDut();
    applyStimulus(16'b101101101, 16'b000001001, 9);
    // The machine now sits in S6. Reset must clear the flag at once,
    // without waiting for a clock edge.
    @(negedge clk);
    checkOutput("pulseHigh", 1'b1);
    #2 reset = 1'b0;
    #1 checkOutput("asyncClear", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Near miss: a single pulse after bit 10.
    applyStimulus(16'b1011101101, 16'b0000000001, 10);
    // 101100 gives no pulse and returns to S0. A fresh pattern then matches.
    resetDut();
    applyStimulus(16'b101100, 16'b000000, 6);
    applyStimulus(16'b101101, 16'b000001, 6);

    // Reset mid-pattern discards the partial match.
    resetDut();
    applyStimulus(16'b10110, 16'b00000, 5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(16'b1, 16'b0, 1);
    applyStimulus(16'b01101, 16'b00001, 5);

    // Random stream compared with a 6-bit shift-register reference model.
    resetDut();
    hist = '0;
    for (int i = 0; i < 10000; i++) begin
      b = 1'($urandom_range(0, 1));
      hist = {hist[4:0], b};
      sendBit(b, (hist == 6'b101101));
    end

    // Let the monitor drain the queue, with a bound on the wait.
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_detector.md
# sequence_detector

Serial bit-stream pattern detector that watches a 1-bit input sampled on each rising clock edge and flags every occurrence of the fixed pattern 1-0-1-1-0-1, oldest bit first. It is a Moore finite-state machine, so the flag depends only on the registered state. It sits between a serial data source and any logic that reacts to the pattern, and overlapping occurrences are detected.

## Interface
- No parameters; the pattern is fixed at 101101.
- clk  input  1  system clock; all state updates occur on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 forces reset immediately; released synchronously by the environment).
- in  input  1  serial data bit, sampled on each rising edge of clk.
- detected  output  1  high for the cycle in which the last six sampled bits equal 101101.

## Operation
- State register, 3-bit binary encoding, states named by prefix length matched:
  - S0 = none
  - S1 = "1"
  - S2 = "10"
  - S3 = "101"
  - S4 = "1011"
  - S5 = "10110"
  - S6 = full match
- Transitions on rising clk edge, written as in=0 / in=1:
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S2 / S4
  - S4: S5 / S1
  - S5: S0 / S6
  - S6: S2 / S4. S6 carries the overlap suffix "101", so it behaves as S3.
- Unused encoding (3'b111) transitions to S0 on the next edge, and detected = 0 in that encoding.
- detected = 1 if and only if state = S6. The output is decoded from the state register only, with no combinational path from in.
- Detection is overlapping: a trailing "101" of one match counts toward the next match.

## Timing
- Reset: while reset = 0, state = S0 and detected = 0 asynchronously, regardless of clk and in.
- First sampling edge: the first rising edge with reset = 1 samples in.
- Latency: detected rises on the same rising edge that samples the sixth pattern bit, so it is visible one register delay after that edge. It stays high for exactly one clock cycle.
- Back-to-back detections: S6 can never be followed directly by S6, so detected can never be high two cycles in a row. The minimum spacing between rising edges of detected is 3 cycles (the overlapping stream 101101101).
- Reset mid-pattern: asserting reset aborts any partial match. After release, a complete fresh 6-bit pattern is required before detected rises.
- in must be stable around the rising edge of clk. No other handshake exists.

## Test plan
- Reset check: hold reset = 0 for 2 cycles while toggling in -> detected = 0 throughout, and state = S0 after release.
- Basic match: release reset, then drive 1,0,1,1,0,1 on six consecutive edges -> detected = 0 on edges 1-5 and 1 only after edge 6. Then drive 0,1,0,1 -> detected stays 0 (state sequence S2, S3, S2, S3).
- Overlap: drive 1,0,1,1,0,1,1,0,1 -> detected pulses after the 6th bit and again after the 9th bit, and is 0 otherwise.
- Near misses: drive 1,0,1,1,1,0,1,1,0,1 -> a single pulse after the 10th bit only. Also drive 1,0,1,1,0,0 -> no pulse, and the state returns to S0.
- Reset mid-pattern: drive 1,0,1,1,0, assert reset for one cycle, then drive 1 -> no pulse. Then drive 0,1,1,0,1 -> pulse after that final bit.
- Random stream: 10,000 random bits checked against a 6-bit shift-register reference model (detected = 1 if and only if the last 6 bits = 101101) -> zero mismatches, and detected is never high on two consecutive cycles.
